// File: rtl/mul_product_combine.sv
// rtl/mul_product_combine.sv - two-stage combiner of 16x16 partial products into a 64-bit product
module mul_product_combine #(
  parameter int HALF_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                flush,
  input  logic                in_valid,
  input  logic                in_src1_signed,
  input  logic                in_src2_signed,
  input  logic                in_hi,
  input  logic [4:0]          in_dst,
  input  logic [2*HALF_W-1:0] in_p1,
  input  logic [2*HALF_W-1:0] in_p2,
  input  logic [2*HALF_W-1:0] in_p3,
  input  logic [2*HALF_W-1:0] in_p4,
  output logic                out_valid,
  output logic [2*HALF_W-1:0] out_result,
  output logic [4*HALF_W-1:0] out_product,
  output logic [4:0]          out_dst
);

  localparam int PW = 2 * HALF_W;
  localparam int FW = 4 * HALF_W;
  localparam int MW = PW + 2;

  logic [MW-1:0] ext_p2;
  logic [MW-1:0] ext_p3;
  logic [MW-1:0] mid;

  logic          s1_valid;
  logic [PW-1:0] s1_p1;
  logic [PW-1:0] s1_p4;
  logic [MW-1:0] s1_mid;
  logic          s1_hi;
  logic [4:0]    s1_dst;

  logic [FW-1:0] mid_wide;
  logic [FW-1:0] product;

  // Stage-1 cross-term sum; the two extra bits hold the carry and the sign
  always_comb begin
    ext_p2 = {{2{in_src2_signed & in_p2[PW-1]}}, in_p2};
    ext_p3 = {{2{in_src1_signed & in_p3[PW-1]}}, in_p3};
    mid    = ext_p2 + ext_p3;
  end

  // Stage-2 final sum; p4 lands at bit 2*HALF_W so its extension bits fall
  // off the top of the product and only its low word is kept in stage 1.
  // The top bit of mid is zero for unsigned sums, so sign-extending it is always safe.
  always_comb begin
    mid_wide = {{(FW-MW){s1_mid[MW-1]}}, s1_mid};
    product  = {{PW{1'b0}}, s1_p1} + (mid_wide << HALF_W) + {s1_p4, {PW{1'b0}}};
  end

  // Pipeline registers: reset clears all, flush clears valids even when stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_p1       <= '0;
      s1_p4       <= '0;
      s1_mid      <= '0;
      s1_hi       <= 1'b0;
      s1_dst      <= '0;
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_product <= '0;
      out_dst     <= '0;
    end else begin
      if (en) begin
        s1_p1       <= in_p1;
        s1_p4       <= in_p4;
        s1_mid      <= mid;
        s1_hi       <= in_hi;
        s1_dst      <= in_dst;
        out_product <= product;
        out_result  <= s1_hi ? product[FW-1:PW] : product[PW-1:0];
        out_dst     <= s1_dst;
      end
      if (flush) begin
        s1_valid  <= 1'b0;
        out_valid <= 1'b0;
      end else if (en) begin
        s1_valid  <= in_valid;
        out_valid <= s1_valid;
      end
    end
  end

endmodule
